// File: rtl/stream_accum_adder_if.sv
// Beat-in / frame-result-out handshake bundle for stream_accum_adder.
// The slave side is the adder itself; the master side feeds beats and consumes results.
interface stream_accum_adder_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 2,
  parameter int OUT_WIDTH = 16
);
  logic                        IN_a_valid;
  logic                        OUT_a_ready;
  logic [NUM_IN*WIDTH-1:0]     IN_a_data;
  logic                        OUT_sum_valid;
  logic                        IN_sum_ready;
  logic [OUT_WIDTH-1:0]        OUT_sum;
  logic                        OUT_ovf;

  modport slave (
    input  IN_a_valid,
    input  IN_a_data,
    input  IN_sum_ready,
    output OUT_a_ready,
    output OUT_sum_valid,
    output OUT_sum,
    output OUT_ovf
  );

  modport master (
    output IN_a_valid,
    output IN_a_data,
    output IN_sum_ready,
    input  OUT_a_ready,
    input  OUT_sum_valid,
    input  OUT_sum,
    input  OUT_ovf
  );
endinterface

// File: rtl/stream_accum_adder.sv
// Frame accumulator: sums NUM_IN operands per beat over BEATS beats on top of a constant,
// then holds the result (with sticky overflow) on a valid/ready output.
module stream_accum_adder #(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 2,
  parameter int OUT_WIDTH = 16,
  parameter int BEATS     = 4,
  parameter int CONST     = 2000,
  parameter int SATURATE  = 0
) (
  input  logic                 IN_clk,
  input  logic                 IN_rst_n,
  input  logic                 IN_clear,
  stream_accum_adder_if.slave  bus
);

  localparam int SUM_W = OUT_WIDTH + $clog2(NUM_IN) + WIDTH + 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [OUT_WIDTH-1:0] CONST_T  = OUT_WIDTH'(CONST);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [OUT_WIDTH-1:0]  r_acc;
  logic                  r_ovf;
  logic                  r_sum_valid;
  logic [OUT_WIDTH-1:0]  r_sum;
  logic                  r_sum_ovf;

  logic                  w_a_ready;
  logic                  w_accept;
  logic                  w_last;
  logic [SUM_W-1:0]      w_ext [NUM_IN];
  logic [SUM_W-1:0]      w_beat_sum;
  logic [SUM_W-1:0]      w_t;
  logic                  w_over;
  logic [OUT_WIDTH-1:0]  w_acc_new;
  logic                  w_ovf_new;

  // Operands are zero-extended to the full sum width so no partial sum can truncate.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ext
      assign w_ext[gi] = SUM_W'(bus.IN_a_data[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  always_comb begin
    w_beat_sum = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_beat_sum = w_beat_sum + w_ext[k];
    end
  end

  assign w_t       = SUM_W'(r_acc) + w_beat_sum;
  assign w_over    = |w_t[SUM_W-1:OUT_WIDTH];
  assign w_acc_new = (w_over && (SATURATE != 0)) ? {OUT_WIDTH{1'b1}} : w_t[OUT_WIDTH-1:0];
  assign w_ovf_new = r_ovf | w_over;

  assign w_accept  = bus.IN_a_valid & w_a_ready;
  assign w_last    = (r_cnt == LAST_CNT);

  // State register
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear overrides both the final-beat transition and the handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACC: begin
        if (!IN_clear && w_accept && w_last) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (IN_clear || bus.IN_sum_ready) begin
          w_state_next = ST_ACC;
        end
      end
      default: w_state_next = ST_ACC;
    endcase
  end

  // Output decode: ready depends on registered state only
  always_comb begin
    w_a_ready = (r_state == ST_ACC);
  end

  // Datapath: accumulator, beat counter and the registered frame result
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      r_cnt       <= '0;
      r_acc       <= CONST_T;
      r_ovf       <= 1'b0;
      r_sum_valid <= 1'b0;
      r_sum       <= '0;
      r_sum_ovf   <= 1'b0;
    end else if (IN_clear) begin
      r_cnt       <= '0;
      r_acc       <= CONST_T;
      r_ovf       <= 1'b0;
      r_sum_valid <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_sum       <= w_acc_new;
        r_sum_ovf   <= w_ovf_new;
        r_sum_valid <= 1'b1;
        r_acc       <= CONST_T;
        r_ovf       <= 1'b0;
        r_cnt       <= '0;
      end else begin
        r_acc       <= w_acc_new;
        r_ovf       <= w_ovf_new;
        r_cnt       <= r_cnt + CNT_W'(1);
      end
    end else if (r_sum_valid && bus.IN_sum_ready) begin
      r_sum_valid <= 1'b0;
    end
  end

  assign bus.OUT_a_ready   = w_a_ready;
  assign bus.OUT_sum_valid = r_sum_valid;
  assign bus.OUT_sum       = r_sum;
  assign bus.OUT_ovf       = r_sum_ovf;

endmodule
